// File: rtl/alarm_ctrl.sv
// alarm_ctrl: BCD seconds alarm with ringing tone, auto-timeout and dismiss.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and its second counter.
module alarm_ctrl #(
   parameter int TONE_DIV   = 25000,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1s,
   input  logic [3:0] cur_ed,
   input  logic [3:0] cur_des,
   input  logic [3:0] cur_sot,
   input  logic       set_we,
   input  logic [3:0] set_ed,
   input  logic [3:0] set_des,
   input  logic [3:0] set_sot,
   input  logic       arm,
   input  logic       snooze,
   input  logic       dismiss,
   output logic       buzz,
   output logic       ringing,
   output logic       armed,
   output logic [1:0] state
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ARMED  = 2'd1;
   localparam logic [1:0] RING   = 2'd2;
   localparam logic [1:0] SNOOZE = 2'd3;
   localparam int DW = TONE_DIV > 1 ? $clog2(TONE_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(TONE_DIV - 1);

   logic [3:0]    sp_ed, sp_des, sp_sot;
   logic [DW-1:0] div;
   logic [7:0]    ring_cnt;
   logic [1:0]    nxt;
   logic          set_ok, match, ring_done, div_wrap, snz_req, snz_done, in_ring;

   assign set_ok    = set_we && set_ed <= 4'd9 && set_des <= 4'd9 && set_sot <= 4'd9;
   assign match     = tick_1s && cur_ed == sp_ed && cur_des == sp_des && cur_sot == sp_sot;
   assign ring_done = tick_1s && ring_cnt >= 8'(RING_SEC - 1);
   assign div_wrap  = div == DIV_MAX;
   assign in_ring   = state == RING && nxt == RING;

`ifdef ALARM_SNOOZE_EN
   logic [7:0] snz_cnt;

   assign snz_req  = snooze;
   assign snz_done = tick_1s && snz_cnt >= 8'(SNOOZE_SEC - 1);

   always_ff @(posedge clk)
      if (rst || state != SNOOZE || nxt != SNOOZE) snz_cnt <= '0;
      else if (tick_1s && snz_cnt != 8'hFF) snz_cnt <= snz_cnt + 8'd1;
`else
   // snooze stays a port so both builds share one pinout; it never acts here
   assign snz_req  = snooze & 1'b0;
   assign snz_done = 1'b0;
`endif

   always_comb begin
      nxt = state;
      if (dismiss && state != IDLE) nxt = IDLE;
      else if (state == IDLE)       nxt = arm ? ARMED : IDLE;
      else if (state == ARMED)      nxt = match ? RING : ARMED;
      else if (state == RING)       nxt = snz_req ? SNOOZE : ring_done ? ARMED : RING;
      else                          nxt = snz_done ? RING : SNOOZE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ringing  <= 1'b0;
         armed    <= 1'b0;
         buzz     <= 1'b0;
         div      <= '0;
         ring_cnt <= '0;
         sp_ed    <= '0;
         sp_des   <= '0;
         sp_sot   <= '0;
      end else begin
         state   <= nxt;
         ringing <= nxt == RING;
         armed   <= nxt != IDLE;
         if (set_ok) begin
            sp_ed  <= set_ed;
            sp_des <= set_des;
            sp_sot <= set_sot;
         end
         // any cycle not spent inside RING leaves the tone counters clear for the next entry
         if (!in_ring) begin
            div      <= '0;
            ring_cnt <= '0;
            buzz     <= 1'b0;
         end else if (tick_1s) begin
            div      <= '0;
            buzz     <= 1'b0;
            ring_cnt <= ring_cnt == 8'hFF ? ring_cnt : ring_cnt + 8'd1;
         end else begin
            div  <= div_wrap ? '0 : div + 1'b1;
            buzz <= ring_cnt[0] ? 1'b0 : buzz ^ div_wrap;
         end
      end
   end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed plus random stimulus against a behavioural alarm model.
module tb_alarm_ctrl;
   localparam int TD = 4, RS = 3, SS = 2;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif

   logic       clk = 1'b0, rst, tick_1s, set_we, arm, snooze, dismiss;
   logic [3:0] cur_ed, cur_des, cur_sot, set_ed, set_des, set_sot;
   logic       buzz, ringing, armed;
   logic [1:0] state;

   alarm_ctrl #(.TONE_DIV(TD), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
      .clk(clk), .rst(rst), .tick_1s(tick_1s),
      .cur_ed(cur_ed), .cur_des(cur_des), .cur_sot(cur_sot),
      .set_we(set_we), .set_ed(set_ed), .set_des(set_des), .set_sot(set_sot),
      .arm(arm), .snooze(snooze), .dismiss(dismiss),
      .buzz(buzz), .ringing(ringing), .armed(armed), .state(state)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int m_state, m_sp, m_rs, m_ph, m_snz;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic model_step;
      int old_sp, cur;
      old_sp = m_sp;
      cur = cur_sot * 100 + cur_des * 10 + cur_ed;
      if (rst) begin
         m_state = 0; m_sp = 0; m_rs = 0; m_ph = 0; m_snz = 0;
         return;
      end
      if (set_we && set_ed < 10 && set_des < 10 && set_sot < 10)
         m_sp = set_sot * 100 + set_des * 10 + set_ed;
      case (m_state)
         0: if (arm) m_state = 1;
         1: if (dismiss) m_state = 0;
            else if (tick_1s && cur == old_sp) begin m_state = 2; m_rs = 0; m_ph = 0; end
         2: if (dismiss) m_state = 0;
            else if (SNZ && snooze) begin m_state = 3; m_snz = 0; end
            else if (tick_1s) begin
               m_rs++; m_ph = 0;
               if (m_rs == RS) m_state = 1;
            end else m_ph++;
         default: if (dismiss) m_state = 0;
            else if (tick_1s) begin
               m_snz++;
               if (m_snz == SS) begin m_state = 2; m_rs = 0; m_ph = 0; end
            end
      endcase
   endtask

   task automatic step;
      int exp_buzz;
      @(posedge clk);
      model_step();
      #1;
      exp_buzz = (m_state == 2 && m_rs % 2 == 0 && (m_ph / TD) % 2 == 1) ? 1 : 0;
      check("state", int'(state), m_state);
      check("buzz", int'(buzz), exp_buzz);
      check("ringing", int'(ringing), m_state == 2 ? 1 : 0);
      check("armed", int'(armed), m_state != 0 ? 1 : 0);
      @(negedge clk);
      {rst, tick_1s, set_we, arm, snooze, dismiss} = '0;
   endtask

   task automatic cur_set(input int s, input int d, input int e);
      cur_sot = 4'(s); cur_des = 4'(d); cur_ed = 4'(e);
   endtask

   initial begin
      {tick_1s, set_we, arm, snooze, dismiss} = '0;
      {cur_ed, cur_des, cur_sot, set_ed, set_des, set_sot} = '0;
      rst = 1'b1;
      step();
      check("reset_state", int'(state), 0);
      set_we = 1; set_ed = 1; set_des = 2; set_sot = 3;
      step();
      arm = 1;
      step();
      check("armed_after_arm", int'(state), 1);
      cur_set(3, 2, 1); tick_1s = 1;
      step();
      check("match_ring", int'(state), 2);
      check("entry_buzz", int'(buzz), 0);
      repeat (12) step();
      tick_1s = 1; step();
      repeat (6) step();
      tick_1s = 1; step();
      repeat (3) step();
      tick_1s = 1; step();
      check("timeout_armed", int'(state), 1);
      check("timeout_buzz", int'(buzz), 0);
      tick_1s = 1; step();
      snooze = 1; step();
      check("snooze_state", int'(state), SNZ ? 3 : 2);
      repeat (2) step();
      tick_1s = 1; step();
      step();
      tick_1s = 1; step();
      check("resnooze_ring", int'(state), 2);
      repeat (5) step();
      dismiss = 1; snooze = 1; step();
      check("dismiss_wins", int'(state), 0);
      check("dismiss_armed", int'(armed), 0);
      set_we = 1; set_ed = 4'hA; set_des = 0; set_sot = 0;
      step();
      arm = 1; step();
      tick_1s = 1; step();
      check("bad_write_kept", int'(state), 2);
      repeat (5) step();
      rst = 1; step();
      check("rst_mid_ring", int'(state), 0);
      check("rst_buzz", int'(buzz), 0);
      arm = 1; step();
      cur_set(0, 0, 0); tick_1s = 1; step();
      check("sp_zero_after_rst", int'(state), 2);
      for (int i = 0; i < 3000; i++) begin
         tick_1s = $urandom_range(0, 7) == 0;
         arm     = $urandom_range(0, 9) == 0;
         snooze  = $urandom_range(0, 29) == 0;
         dismiss = $urandom_range(0, 39) == 0;
         rst     = $urandom_range(0, 199) == 0;
         set_we  = $urandom_range(0, 29) == 0;
         cur_set($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         set_ed  = $urandom_range(0, 5) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 1));
         set_des = 4'($urandom_range(0, 1));
         set_sot = 4'($urandom_range(0, 1));
         step();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
